// File: rtl/tcdm_wide_narrow_arbiter.sv
// Arbitrates NrWide wide TCDM ports and NrPorts narrow ports onto NrPorts narrow banks.
// Per-lane source FIFOs steer bank responses back to the issuing port.
module tcdm_wide_narrow_arbiter #(
  parameter int unsigned NarrowDataWidth = 32,
  parameter int unsigned WideDataWidth   = 128,
  parameter int unsigned NrWide          = 2,
  parameter int unsigned RspDepth        = 4,
  parameter int unsigned MaxStall        = 4,
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned IniAddrWidth    = 4,
  parameter int unsigned NrPorts         = WideDataWidth / NarrowDataWidth,
  localparam int unsigned NarrowBeWidth  = NarrowDataWidth / 8,
  localparam int unsigned WideBeWidth    = WideDataWidth / 8,
  localparam int unsigned NarrowReqWidth = IniAddrWidth + AddrWidth + NarrowBeWidth + 1 + NarrowDataWidth,
  localparam int unsigned WideReqWidth   = AddrWidth + WideBeWidth + 1 + WideDataWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NrPorts*NarrowReqWidth-1:0]   slv_narrow_req_i,
  input  logic [NrPorts-1:0]                  slv_narrow_req_valid_i,
  output logic [NrPorts-1:0]                  slv_narrow_req_ready_o,
  output logic [NrPorts*NarrowDataWidth-1:0]  slv_narrow_rsp_o,
  output logic [NrPorts-1:0]                  slv_narrow_rsp_valid_o,
  input  logic [NrPorts-1:0]                  slv_narrow_rsp_ready_i,
  input  logic [NrWide*WideReqWidth-1:0]      slv_wide_req_i,
  input  logic [NrWide-1:0]                   slv_wide_req_valid_i,
  output logic [NrWide-1:0]                   slv_wide_req_ready_o,
  output logic [NrWide*WideDataWidth-1:0]     slv_wide_rsp_o,
  output logic [NrWide-1:0]                   slv_wide_rsp_valid_o,
  input  logic [NrWide-1:0]                   slv_wide_rsp_ready_i,
  output logic [NrPorts*NarrowReqWidth-1:0]   mst_req_o,
  output logic [NrPorts-1:0]                  mst_req_valid_o,
  input  logic [NrPorts-1:0]                  mst_req_ready_i,
  input  logic [NrPorts*NarrowDataWidth-1:0]  mst_rsp_i,
  input  logic [NrPorts-1:0]                  mst_rsp_valid_i,
  output logic [NrPorts-1:0]                  mst_rsp_ready_o
);

  localparam int unsigned WidxWidth  = (NrWide > 1) ? $clog2(NrWide) : 1;
  localparam int unsigned SrcWidth   = $clog2(NrWide + 1);
  localparam int unsigned PtrWidth   = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned CntWidth   = $clog2(RspDepth + 1);
  localparam int unsigned StallWidth = $clog2(MaxStall + 1);

  if (NrPorts * NarrowDataWidth != WideDataWidth) begin : gen_width_check
    $error("WideDataWidth must equal NrPorts*NarrowDataWidth");
  end

  logic                   lock_q;
  logic [WidxWidth-1:0]   widx_q, rr_q;
  logic [NrPorts-1:0]     done_q;
  logic [StallWidth-1:0]  stall_q [NrPorts];
  logic [SrcWidth-1:0]    mem [NrPorts][RspDepth];
  logic [PtrWidth-1:0]    wptr_q [NrPorts];
  logic [PtrWidth-1:0]    rptr_q [NrPorts];
  logic [CntWidth-1:0]    cnt_q [NrPorts];

  logic                   found, gnt, all_done;
  int unsigned            cand;
  logic [WidxWidth-1:0]   pick, widx, next_rr;
  logic [WideReqWidth-1:0] wide_req;
  logic [NrPorts-1:0]     wide_own, wide_hs, narrow_hs, full, empty, push, pop, rsp_ready;
  logic [NrWide-1:0]      wide_rsp_valid;
  logic [SrcWidth-1:0]    head [NrPorts];
  logic [SrcWidth-1:0]    push_code [NrPorts];

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int unsigned k = 0; k < NrWide; k++) begin
      cand = (32'(rr_q) + k) % NrWide;
      if (!found && slv_wide_req_valid_i[cand]) begin
        found = 1'b1;
        pick  = WidxWidth'(cand);
      end
    end
    gnt      = lock_q || found;
    widx     = lock_q ? widx_q : pick;
    next_rr  = WidxWidth'((32'(widx) + 1) % NrWide);
    wide_req = slv_wide_req_i[32'(widx)*WideReqWidth +: WideReqWidth];
  end

  // Lane mux: a saturated stall counter lets a waiting narrow request preempt the wide lane.
  always_comb begin
    all_done = gnt;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      full[i]     = (cnt_q[i] == CntWidth'(RspDepth));
      wide_own[i] = gnt && !done_q[i] &&
                    !(stall_q[i] == StallWidth'(MaxStall) && slv_narrow_req_valid_i[i]);
      mst_req_o[i*NarrowReqWidth +: NarrowReqWidth] = wide_own[i] ?
        {{IniAddrWidth{1'b0}},
         wide_req[WideDataWidth+1+WideBeWidth +: AddrWidth],
         wide_req[WideDataWidth+1+i*NarrowBeWidth +: NarrowBeWidth],
         wide_req[WideDataWidth],
         wide_req[i*NarrowDataWidth +: NarrowDataWidth]} :
        slv_narrow_req_i[i*NarrowReqWidth +: NarrowReqWidth];
      mst_req_valid_o[i]        = !rst_i && !full[i] && (wide_own[i] || slv_narrow_req_valid_i[i]);
      slv_narrow_req_ready_o[i] = !rst_i && !full[i] && !wide_own[i] && mst_req_ready_i[i];
      wide_hs[i]   = wide_own[i] && !full[i] && mst_req_ready_i[i];
      narrow_hs[i] = slv_narrow_req_valid_i[i] && slv_narrow_req_ready_o[i];
      push[i]      = mst_req_valid_o[i] && mst_req_ready_i[i];
      push_code[i] = wide_own[i] ? SrcWidth'(32'(widx) + 1) : '0;
      if (!(done_q[i] || wide_hs[i])) all_done = 1'b0;
    end
    for (int unsigned w = 0; w < NrWide; w++)
      slv_wide_req_ready_o[w] = !rst_i && all_done && (widx == WidxWidth'(w));
  end

  always_comb begin
    for (int unsigned i = 0; i < NrPorts; i++) begin
      empty[i] = (cnt_q[i] == '0);
      head[i]  = mem[i][rptr_q[i]];
    end
    for (int unsigned w = 0; w < NrWide; w++) begin
      wide_rsp_valid[w] = 1'b1;
      for (int unsigned i = 0; i < NrPorts; i++)
        if (!(mst_rsp_valid_i[i] && !empty[i] && head[i] == SrcWidth'(w + 1)))
          wide_rsp_valid[w] = 1'b0;
    end
    for (int unsigned i = 0; i < NrPorts; i++) begin
      slv_narrow_rsp_valid_o[i] = !rst_i && mst_rsp_valid_i[i] && !empty[i] && (head[i] == '0);
      rsp_ready[i] = 1'b0;
      if (!empty[i]) begin
        if (head[i] == '0) rsp_ready[i] = slv_narrow_rsp_ready_i[i];
        for (int unsigned w = 0; w < NrWide; w++)
          if (head[i] == SrcWidth'(w + 1))
            rsp_ready[i] = wide_rsp_valid[w] && slv_wide_rsp_ready_i[w];
      end
      mst_rsp_ready_o[i] = !rst_i && rsp_ready[i];
      pop[i]             = mst_rsp_valid_i[i] && mst_rsp_ready_o[i];
    end
    slv_wide_rsp_valid_o = rst_i ? '0 : wide_rsp_valid;
  end

  assign slv_narrow_rsp_o = mst_rsp_i;
  assign slv_wide_rsp_o   = {NrWide{mst_rsp_i}};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q <= 1'b0;
      widx_q <= '0;
      rr_q   <= '0;
      done_q <= '0;
      for (int unsigned i = 0; i < NrPorts; i++) begin
        stall_q[i] <= '0;
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      if (all_done) begin
        lock_q <= 1'b0;
        done_q <= '0;
        rr_q   <= next_rr;
      end else if (gnt) begin
        lock_q <= 1'b1;
        widx_q <= widx;
        done_q <= done_q | wide_hs;
      end
      for (int unsigned i = 0; i < NrPorts; i++) begin
        if (!slv_narrow_req_valid_i[i] || narrow_hs[i])
          stall_q[i] <= '0;
        else if (wide_own[i] && stall_q[i] != StallWidth'(MaxStall))
          stall_q[i] <= stall_q[i] + StallWidth'(1);
        if (push[i])
          wptr_q[i] <= (wptr_q[i] == PtrWidth'(RspDepth - 1)) ? '0 : wptr_q[i] + PtrWidth'(1);
        if (pop[i])
          rptr_q[i] <= (rptr_q[i] == PtrWidth'(RspDepth - 1)) ? '0 : rptr_q[i] + PtrWidth'(1);
        if (push[i] && !pop[i])
          cnt_q[i] <= cnt_q[i] + CntWidth'(1);
        else if (!push[i] && pop[i])
          cnt_q[i] <= cnt_q[i] - CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NrPorts; i++)
      if (push[i]) mem[i][wptr_q[i]] <= push_code[i];
  end

endmodule

// File: tb/tb_tcdm_wide_narrow_arbiter.sv
// Directed bench for tcdm_wide_narrow_arbiter: a vector table checked from reset,
// plus multi-cycle sequences for partial lanes, round-robin, starvation, ordering and reset.
module tb_tcdm_wide_narrow_arbiter;
  localparam int unsigned NW = 32, WW = 128, NP = 4, NWIDE = 2, AW = 32, IW = 4;
  localparam int unsigned NRW = IW + AW + NW/8 + 1 + NW;
  localparam int unsigned WRW = AW + WW/8 + 1 + WW;

  logic clk = 1'b0, rst = 1'b0;
  logic [NP*NRW-1:0]   nreq, mreq;
  logic [NP-1:0]       nv, nr, nrsp_v, nrsp_r, mv, br, mrsp_v, mrsp_r;
  logic [NP*NW-1:0]    nrsp, mrsp;
  logic [NWIDE*WRW-1:0] wreq;
  logic [NWIDE-1:0]    wv, wr, wrsp_v, wrsp_r;
  logic [NWIDE*WW-1:0] wrsp;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  tcdm_wide_narrow_arbiter #(
    .NarrowDataWidth(NW), .WideDataWidth(WW), .NrWide(NWIDE), .RspDepth(2),
    .MaxStall(4), .AddrWidth(AW), .IniAddrWidth(IW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_narrow_req_i(nreq), .slv_narrow_req_valid_i(nv), .slv_narrow_req_ready_o(nr),
    .slv_narrow_rsp_o(nrsp), .slv_narrow_rsp_valid_o(nrsp_v), .slv_narrow_rsp_ready_i(nrsp_r),
    .slv_wide_req_i(wreq), .slv_wide_req_valid_i(wv), .slv_wide_req_ready_o(wr),
    .slv_wide_rsp_o(wrsp), .slv_wide_rsp_valid_o(wrsp_v), .slv_wide_rsp_ready_i(wrsp_r),
    .mst_req_o(mreq), .mst_req_valid_o(mv), .mst_req_ready_i(br),
    .mst_rsp_i(mrsp), .mst_rsp_valid_i(mrsp_v), .mst_rsp_ready_o(mrsp_r)
  );

  function automatic logic [NRW-1:0] narrow_pl(int unsigned i);
    return {IW'(i + 1), AW'(32'h0000_1000 + i), 4'hF, 1'b1, NW'(32'hA000_0000 + i)};
  endfunction

  function automatic logic [WW-1:0] wide_wdata(int unsigned w);
    logic [WW-1:0] d;
    for (int unsigned i = 0; i < NP; i++) d[i*NW +: NW] = NW'(32'hB000_0000 + w*256 + i);
    return d;
  endfunction

  function automatic logic [WW/8-1:0] wide_be(int unsigned w);
    return (w == 0) ? 16'h4321 : 16'h8765;
  endfunction

  function automatic logic [WRW-1:0] wide_pl(int unsigned w);
    return {AW'(32'hC000_0000 + w), wide_be(w), (w == 1), wide_wdata(w)};
  endfunction

  function automatic logic [NRW-1:0] wide_lane(int unsigned w, int unsigned i);
    logic [WW-1:0]   d;
    logic [WW/8-1:0] b;
    d = wide_wdata(w);
    b = wide_be(w);
    return {IW'(0), AW'(32'hC000_0000 + w), b[i*4 +: 4], (w == 1), d[i*NW +: NW]};
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set(input logic [3:0] n, input logic [1:0] w, input logic [3:0] b, input logic [3:0] r);
    nv = n; wv = w; br = b; mrsp_v = r;
  endtask

  task automatic cyc(input logic [3:0] n, input logic [1:0] w, input logic [3:0] b, input logic [3:0] r);
    @(negedge clk);
    set(n, w, b, r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set(4'b0, 2'b0, 4'b0, 4'b0);
    #1 rst = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [3:0] nv; logic [1:0] wv; logic [3:0] br; int unsigned wsel;
    logic [3:0] mv; logic [3:0] nr; logic [1:0] wr; logic [3:0] wl;
  } vec_t;
  vec_t vecs[6];

  localparam logic [WW-1:0] RspCat = 128'hD0000003_D0000002_D0000001_D0000000;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int unsigned i = 0; i < NP; i++) begin
      nreq[i*NRW +: NRW] = narrow_pl(i);
      mrsp[i*NW +: NW]   = NW'(32'hD000_0000 + i);
    end
    for (int unsigned w = 0; w < NWIDE; w++) wreq[w*WRW +: WRW] = wide_pl(w);
    nrsp_r = '1;
    wrsp_r = '1;
    set(4'b0, 2'b0, 4'b0, 4'b0);

    vecs[0] = '{nv:4'b1111, wv:2'b00, br:4'b1111, wsel:0, mv:4'b1111, nr:4'b1111, wr:2'b00, wl:4'b0000};
    vecs[1] = '{nv:4'b0000, wv:2'b01, br:4'b1111, wsel:0, mv:4'b1111, nr:4'b0000, wr:2'b01, wl:4'b1111};
    vecs[2] = '{nv:4'b1111, wv:2'b10, br:4'b1111, wsel:1, mv:4'b1111, nr:4'b0000, wr:2'b10, wl:4'b1111};
    vecs[3] = '{nv:4'b0101, wv:2'b11, br:4'b1011, wsel:0, mv:4'b1111, nr:4'b0000, wr:2'b00, wl:4'b1111};
    vecs[4] = '{nv:4'b1010, wv:2'b00, br:4'b0101, wsel:0, mv:4'b1010, nr:4'b0101, wr:2'b00, wl:4'b0000};
    vecs[5] = '{nv:4'b0000, wv:2'b00, br:4'b0000, wsel:0, mv:4'b0000, nr:4'b0000, wr:2'b00, wl:4'b0000};

    // Outputs held low while reset is asserted
    @(negedge clk);
    rst = 1'b1;
    set(4'b1111, 2'b11, 4'b1111, 4'b1111);
    #1 check("reset outputs", {mv, nr, wr, nrsp_v, wrsp_v, mrsp_r}, '0);
    rst = 1'b0;

    for (int unsigned k = 0; k < 6; k++) begin
      do_reset();
      set(vecs[k].nv, vecs[k].wv, vecs[k].br, 4'b0000);
      #1;
      check($sformatf("vec%0d mst_valid", k), mv, vecs[k].mv);
      check($sformatf("vec%0d narrow_ready", k), nr, vecs[k].nr);
      check($sformatf("vec%0d wide_ready", k), wr, vecs[k].wr);
      for (int unsigned i = 0; i < NP; i++)
        check($sformatf("vec%0d lane%0d payload", k, i), mreq[i*NRW +: NRW],
              vecs[k].wl[i] ? wide_lane(vecs[k].wsel, i) : narrow_pl(i));
    end

    // Partial lanes: lane 2 stalls 3 cycles, narrow 0 takes lane 0 once it is done
    do_reset();
    cyc(4'b0001, 2'b01, 4'b1011, 4'b0000);
    check("partial c0", {mv, nr, wr}, {4'b1111, 4'b0000, 2'b00});
    cyc(4'b0001, 2'b01, 4'b1011, 4'b0000);
    check("partial c1", {mv, nr, wr}, {4'b0101, 4'b1011, 2'b00});
    check("partial c1 lane0 narrow", mreq[0 +: NRW], narrow_pl(0));
    cyc(4'b0001, 2'b01, 4'b1011, 4'b0000);
    check("partial c2 lane0 full", {mv, nr, wr}, {4'b0100, 4'b1010, 2'b00});
    cyc(4'b0001, 2'b01, 4'b1111, 4'b0000);
    check("partial c3 complete", {mv, nr, wr}, {4'b0100, 4'b1010, 2'b01});

    // Round-robin with responses drained every cycle
    do_reset();
    cyc(4'b0000, 2'b11, 4'b1111, 4'b1111);
    check("rr c0", {wr, wrsp_v}, {2'b01, 2'b00});
    cyc(4'b0000, 2'b11, 4'b1111, 4'b1111);
    check("rr c1", {wr, wrsp_v, mrsp_r}, {2'b10, 2'b01, 4'b1111});
    check("rr c1 rdata", wrsp[0 +: WW], RspCat);
    cyc(4'b0000, 2'b11, 4'b1111, 4'b1111);
    check("rr c2", {wr, wrsp_v}, {2'b01, 2'b10});
    cyc(4'b0000, 2'b11, 4'b1111, 4'b1111);
    check("rr c3", {wr, wrsp_v, nrsp_v}, {2'b10, 2'b01, 4'b0000});

    // Starvation: narrow 1 wins on the fifth cycle, then its counter restarts
    do_reset();
    for (int unsigned c = 0; c < 4; c++) begin
      cyc(4'b0010, 2'b11, 4'b1111, 4'b1111);
      check($sformatf("starve c%0d", c), {nr, wr}, {4'b0000, (c % 2 == 0) ? 2'b01 : 2'b10});
    end
    cyc(4'b0010, 2'b11, 4'b1111, 4'b1111);
    check("starve c4 narrow wins", {mv, nr, wr}, {4'b1111, 4'b0010, 2'b00});
    check("starve c4 lane1 payload", mreq[NRW +: NRW], narrow_pl(1));
    cyc(4'b0010, 2'b11, 4'b1111, 4'b1111);
    check("starve c5 cleared", {nr, wr, nrsp_v}, {4'b1101, 2'b01, 4'b0010});

    // Interleaved narrow / wide / narrow on lane 0
    do_reset();
    cyc(4'b0001, 2'b00, 4'b1111, 4'b0000);
    check("ilv c0", {mv, wr}, {4'b0001, 2'b00});
    cyc(4'b0000, 2'b01, 4'b1111, 4'b0000);
    check("ilv c1", {mv, wr}, {4'b1111, 2'b01});
    cyc(4'b0001, 2'b00, 4'b1111, 4'b0001);
    check("ilv c2", {mv, nrsp_v, wrsp_v, mrsp_r}, {4'b0000, 4'b0001, 2'b00, 4'b0001});
    cyc(4'b0001, 2'b00, 4'b1111, 4'b0001);
    check("ilv c3", {mv, nrsp_v, wrsp_v, mrsp_r}, {4'b0001, 4'b0000, 2'b00, 4'b0000});
    cyc(4'b0000, 2'b00, 4'b1111, 4'b1111);
    check("ilv c4", {nrsp_v, wrsp_v, mrsp_r}, {4'b0000, 2'b01, 4'b1111});
    check("ilv c4 rdata", wrsp[0 +: WW], RspCat);
    cyc(4'b0000, 2'b00, 4'b1111, 4'b0001);
    check("ilv c5", {nrsp_v, wrsp_v, mrsp_r}, {4'b0001, 2'b00, 4'b0001});
    cyc(4'b0000, 2'b00, 4'b1111, 4'b1111);
    check("ilv c6 empty", {nrsp_v, wrsp_v, mrsp_r}, {4'b0000, 2'b00, 4'b0000});

    // Backpressure: third request on a lane with two outstanding is held off
    do_reset();
    cyc(4'b0001, 2'b00, 4'b1111, 4'b0000);
    check("bp c0", {mv, nr}, {4'b0001, 4'b1111});
    cyc(4'b0001, 2'b00, 4'b1111, 4'b0000);
    check("bp c1", {mv, nr}, {4'b0001, 4'b1111});
    cyc(4'b0001, 2'b00, 4'b1111, 4'b0000);
    check("bp c2 blocked", {mv, nr}, {4'b0000, 4'b1110});

    // Reset in the middle of a locked wide transaction
    do_reset();
    cyc(4'b0000, 2'b01, 4'b1011, 4'b0000);
    check("midrst c0", {mv, wr}, {4'b1111, 2'b00});
    @(negedge clk);
    rst = 1'b1;
    #1 check("midrst asserted", {mv, nr, wr, nrsp_v, wrsp_v, mrsp_r}, '0);
    rst = 1'b0;
    set(4'b1111, 2'b00, 4'b1111, 4'b1111);
    #1 check("midrst cleared", {mv, nr, wr, nrsp_v, wrsp_v}, {4'b1111, 4'b1111, 2'b00, 4'b0000, 2'b00});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
